// File: rtl/fproc_meas.sv
// Measurement-result store with per-core fproc request ports.
// Each core blocks on its requested slot until the slot is valid, or reads the free-running timer.
module fproc_meas #(
  parameter int N_CORES            = 4,
  parameter int FPROC_ID_WIDTH     = 8,
  parameter int FPROC_RESULT_WIDTH = 32,
  parameter int N_MEAS             = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0]      fproc_id,
  input  logic [N_CORES-1:0]                     fproc_enable,
  output logic [N_CORES*FPROC_RESULT_WIDTH-1:0]  fproc_data,
  output logic [N_CORES-1:0]                     fproc_ready,
  input  logic                                   meas_write_en,
  input  logic [$clog2(N_MEAS)-1:0]              meas_write_addr,
  input  logic [FPROC_RESULT_WIDTH-1:0]          meas_write_data,
  input  logic                                   meas_clear
);

  localparam int IW = FPROC_ID_WIDTH;
  localparam int RW = FPROC_RESULT_WIDTH;
  localparam int AW = $clog2(N_MEAS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [RW-1:0]     timer;
  logic [RW-1:0]     slot_data [N_MEAS];
  logic [N_MEAS-1:0] slot_valid;
  logic [N_MEAS-1:0] wr_hit;
  logic [N_MEAS-1:0] avail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer <= '0;
    else        timer <= timer + RW'(1);
  end

  // A slot counts as available when written this cycle (bypass) or valid and not being cleared.
  always_comb begin
    wr_hit = '0;
    avail  = '0;
    for (int s = 0; s < N_MEAS; s++) begin
      wr_hit[s] = meas_write_en && (meas_write_addr == AW'(s));
      avail[s]  = wr_hit[s] || (slot_valid[s] && !meas_clear);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int s = 0; s < N_MEAS; s++) slot_data[s] <= '0;
    end else begin
      for (int s = 0; s < N_MEAS; s++) begin
        if (wr_hit[s]) begin
          slot_data[s]  <= meas_write_data;
          slot_valid[s] <= 1'b1;
        end else if (meas_clear) begin
          slot_valid[s] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    state_t        state, state_next;
    logic [IW-1:0] id_in, id_q, id_sel;
    logic [RW-1:0] data_q, load_data, sel_data;
    logic          sel_avail, load;

    assign id_in  = fproc_id[IW*i +: IW];
    assign id_sel = (state == WAIT) ? id_q : id_in;

    always_comb begin
      sel_avail = 1'b0;
      sel_data  = '0;
      for (int s = 0; s < N_MEAS; s++) begin
        if (id_sel == IW'(s)) begin
          sel_avail = avail[s];
          sel_data  = wr_hit[s] ? meas_write_data : slot_data[s];
        end
      end
    end

    always_comb begin
      state_next = state;
      load       = 1'b0;
      load_data  = sel_data;
      case (state)
        IDLE: begin
          if (fproc_enable[i]) begin
            if (id_in >= IW'(N_MEAS)) begin
              state_next = RESP;
              load       = 1'b1;
              load_data  = timer;
            end else if (sel_avail) begin
              state_next = RESP;
              load       = 1'b1;
            end else begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (sel_avail) begin
            state_next = RESP;
            load       = 1'b1;
          end
        end
        RESP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        id_q   <= '0;
        data_q <= '0;
      end else begin
        state <= state_next;
        if (state == IDLE && fproc_enable[i]) id_q <= id_in;
        if (load) data_q <= load_data;
      end
    end

    assign fproc_ready[i]             = (state == RESP);
    assign fproc_data[RW*i +: RW]     = data_q;
  end

endmodule

// File: tb/tb_fproc_meas.sv
// Randomized scoreboard bench for fproc_meas with a transaction-level reference model,
// plus a narrow-timer instance for the wrap-around case.
module tb_fproc_meas;
  localparam int NC = 4;
  localparam int IW = 8;
  localparam int RW = 32;
  localparam int NM = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NC*IW-1:0]     fproc_id = '0;
  logic [NC-1:0]        fproc_enable = '0;
  logic [NC*RW-1:0]     fproc_data;
  logic [NC-1:0]        fproc_ready;
  logic                 meas_write_en = 1'b0;
  logic [3:0]           meas_write_addr = '0;
  logic [RW-1:0]        meas_write_data = '0;
  logic                 meas_clear = 1'b0;

  logic [2*IW-1:0]      id8 = '0;
  logic [1:0]           en8 = '0;
  logic [15:0]          data8;
  logic [1:0]           ready8;

  always #5 clk = ~clk;

  fproc_meas #(.N_CORES(NC), .FPROC_ID_WIDTH(IW), .FPROC_RESULT_WIDTH(RW), .N_MEAS(NM)) dut (
    .clk(clk), .reset(reset), .fproc_id(fproc_id), .fproc_enable(fproc_enable),
    .fproc_data(fproc_data), .fproc_ready(fproc_ready), .meas_write_en(meas_write_en),
    .meas_write_addr(meas_write_addr), .meas_write_data(meas_write_data), .meas_clear(meas_clear)
  );

  fproc_meas #(.N_CORES(2), .FPROC_ID_WIDTH(IW), .FPROC_RESULT_WIDTH(8), .N_MEAS(NM)) dut8 (
    .clk(clk), .reset(reset), .fproc_id(id8), .fproc_enable(en8),
    .fproc_data(data8), .fproc_ready(ready8), .meas_write_en(1'b0),
    .meas_write_addr(4'd0), .meas_write_data(8'd0), .meas_clear(1'b0)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot table, timer as edge count, per-core pending request.
  typedef struct { int cyc; logic [RW-1:0] data; } exp_t;
  exp_t          q [NC][$];
  logic [RW-1:0] m_data [NM];
  bit            m_valid [NM];
  bit            m_wait [NC];
  int            m_wid [NC];
  int            m_resp [NC];
  logic [RW-1:0] last [NC];
  logic [RW-1:0] tmr;
  int            cyc = 0;

  function automatic bit m_avail(input int id);
    return (meas_write_en && int'(meas_write_addr) == id) || (m_valid[id] && !meas_clear);
  endfunction

  function automatic logic [RW-1:0] m_read(input int id);
    return (meas_write_en && int'(meas_write_addr) == id) ? meas_write_data : m_data[id];
  endfunction

  task automatic push(input int i, input logic [RW-1:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.data = d;
    q[i].push_back(e);
    m_wait[i] = 1'b0;
    m_resp[i] = cyc + 1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr = '0;
      for (int s = 0; s < NM; s++) begin m_data[s] = '0; m_valid[s] = 1'b0; end
      for (int i = 0; i < NC; i++) begin
        q[i].delete(); m_wait[i] = 1'b0; m_resp[i] = -1; last[i] = '0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        int id;
        id = int'(fproc_id[IW*i +: IW]);
        if (m_wait[i]) begin
          if (m_avail(m_wid[i])) push(i, m_read(m_wid[i]));
        end else if (fproc_enable[i] && m_resp[i] != cyc) begin
          if (id >= NM)          push(i, tmr);
          else if (m_avail(id))  push(i, m_read(id));
          else begin m_wait[i] = 1'b1; m_wid[i] = id; end
        end
      end
      if (meas_clear) for (int s = 0; s < NM; s++) m_valid[s] = 1'b0;
      if (meas_write_en && meas_write_addr < NM) begin
        m_data[meas_write_addr] = meas_write_data;
        m_valid[meas_write_addr] = 1'b1;
      end
      tmr = tmr + 1;
      cyc++;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      bit er;
      er = 1'b0;
      if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
        er = (q[i][0].cyc == cyc);
        if (er) last[i] = q[i][0].data;
        void'(q[i].pop_front());
      end
      chk($sformatf("ready[%0d]", i), RW'(fproc_ready[i]), RW'(er));
      chk($sformatf("data[%0d]", i), fproc_data[RW*i +: RW], last[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    fproc_enable  = '0;
    meas_write_en = 1'b0;
    meas_clear    = 1'b0;
  endtask

  task automatic wr(input int a, input logic [RW-1:0] d);
    meas_write_en   = 1'b1;
    meas_write_addr = 4'(a);
    meas_write_data = d;
  endtask

  task automatic req(input int i, input int id);
    fproc_enable[i]       = 1'b1;
    fproc_id[IW*i +: IW]  = IW'(id);
  endtask

  task automatic wait_tmr(input logic [RW-1:0] v);
    int n;
    n = 0;
    while (tmr != v && n < 400) begin tick(); n++; end
    if (tmr != v) chk("timer_align", tmr, v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", RW'(fproc_ready), '0);
    chk("rst_data0", fproc_data[RW-1:0], '0);
    chk("rst_data3", fproc_data[4*RW-1 -: RW], '0);
    chk("rst_ready8", RW'(ready8), '0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Valid slot read: one-cycle latency
    wr(3, 32'hDEADBEEF); tick();
    tick();
    req(0, 3); tick();
    chk("hit_ready", RW'(fproc_ready[0]), 1);
    chk("hit_data", fproc_data[RW-1:0], 32'hDEADBEEF);
    tick();
    chk("hit_ready_drop", RW'(fproc_ready[0]), 0);

    // Blocking read released by a later write
    req(1, 5); tick();
    repeat (3) begin chk("wait_no_ready", RW'(fproc_ready[1]), 0); tick(); end
    wr(5, 32'h1234); tick();
    chk("wait_ready", RW'(fproc_ready[1]), 1);
    chk("wait_data", fproc_data[2*RW-1 -: RW], 32'h1234);

    // Write bypass concurrent with clear; clear invalidates other slots
    wr(2, 32'hAAAA0002); tick();
    tick();
    req(2, 7); wr(7, 32'h55); meas_clear = 1'b1; tick();
    chk("byp_ready", RW'(fproc_ready[2]), 1);
    chk("byp_data", fproc_data[3*RW-1 -: RW], 32'h55);
    req(3, 2); tick();
    repeat (3) begin chk("cleared_no_ready", RW'(fproc_ready[3]), 0); tick(); end
    wr(2, 32'h22); tick();
    chk("cleared_release", fproc_data[4*RW-1 -: RW], 32'h22);

    // Timer reads on all cores, then wrap on the narrow instance
    do_reset();
    wait_tmr(100);
    for (int i = 0; i < NC; i++) req(i, NM);
    tick();
    chk("tmr_ready_all", RW'(fproc_ready), RW'(4'hF));
    for (int i = 0; i < NC; i++) chk("tmr_data", fproc_data[RW*i +: RW], 100);
    wait_tmr(255);
    en8 = 2'b01; id8 = {8'd16, 8'd16};
    tick();
    en8 = 2'b10;
    chk("wrap_ready0", RW'(ready8), 2'b01);
    chk("wrap_allones", RW'(data8[7:0]), 8'hFF);
    tick();
    en8 = 2'b00;
    chk("wrap_ready1", RW'(ready8), 2'b10);
    chk("wrap_zero", RW'(data8[15:8]), 0);

    // Reset while waiting drops the request
    req(0, 9); tick();
    tick();
    do_reset();
    wr(9, 32'h99); tick();
    repeat (3) begin
      chk("rst_drop_ready", RW'(fproc_ready[0]), 0);
      chk("rst_drop_data", fproc_data[RW-1:0], 0);
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 19) == 0) req(i, 200);
          else req(i, $urandom_range(0, NM + 2));
        end
      end
      if ($urandom_range(0, 9) < 3) wr($urandom_range(0, NM - 1), $urandom);
      if ($urandom_range(0, 29) == 0) meas_clear = 1'b1;
      tick();
    end

    for (int s = 0; s < NM; s++) begin wr(s, 32'hF000_0000 + s); tick(); end
    repeat (4) tick();
    for (int i = 0; i < NC; i++) chk("drain_empty", RW'(q[i].size() + int'(m_wait[i])), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fproc_meas.md
FPROC_MEAS -- requirements
Module: fproc_meas

Interface
REQ-001 Parameter N_CORES, default 4: number of processor cores served, each with one independent fproc port.
REQ-002 Parameter FPROC_ID_WIDTH, default 8: width of each core's fproc request ID.
REQ-003 Parameter FPROC_RESULT_WIDTH, default 32: width of result data and of the timer.
REQ-004 Parameter N_MEAS, default 16: number of measurement result slots, at least 2 and at most 2^FPROC_ID_WIDTH-1.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-007 Port fproc_id, input, N_CORES*FPROC_ID_WIDTH bits: request ID per core; core i occupies bits [FPROC_ID_WIDTH*(i+1)-1 : FPROC_ID_WIDTH*i].
REQ-008 Port fproc_enable, input, N_CORES bits: one-cycle request strobe per core.
REQ-009 Port fproc_data, output, N_CORES*FPROC_RESULT_WIDTH bits: response data per core, packed the same way as fproc_id.
REQ-010 Port fproc_ready, output, N_CORES bits: one-cycle response strobe per core.
REQ-011 Port meas_write_en, input, 1 bit: write strobe for a measurement result.
REQ-012 Port meas_write_addr, input, clog2(N_MEAS) bits: slot to write.
REQ-013 Port meas_write_data, input, FPROC_RESULT_WIDTH bits: result value to write.
REQ-014 Port meas_clear, input, 1 bit: invalidates all slots for a new shot.

Function
REQ-015 The block SHALL hold N_MEAS slots, each with a data register and a valid bit.
REQ-016 When meas_write_en is high, the block SHALL load the addressed slot's data and set its valid bit at that edge.
REQ-017 When meas_clear is high, the block SHALL clear all valid bits and leave slot data unchanged.
REQ-018 When meas_clear and meas_write_en are high in the same cycle, the written slot SHALL end valid with the new data and all other slots SHALL end invalid.
REQ-019 meas_write_addr >= N_MEAS SHALL be ignored.
REQ-020 A free-running timer of FPROC_RESULT_WIDTH bits SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-021 Each core SHALL have its own FSM with states IDLE, WAIT and RESP.
REQ-022 In IDLE, fproc_enable[i] high SHALL latch fproc_id[i].
REQ-023 An ID >= N_MEAS SHALL go to RESP and return the timer value sampled at the enable edge.
REQ-024 An ID < N_MEAS whose slot is "available" at the enable edge SHALL go to RESP with that slot's data; otherwise the FSM SHALL go to WAIT.
REQ-025 A slot is "available" at an edge when its valid bit is already set (and not cleared in that cycle without a write), or when it is being written in that cycle; a same-cycle write SHALL be bypassed, returning meas_write_data.
REQ-026 In WAIT, at the first edge where the latched slot is available, the FSM SHALL capture that slot's data and go to RESP.
REQ-027 In WAIT, meas_clear alone SHALL NOT abort the wait.
REQ-028 RESP SHALL last exactly one cycle with fproc_ready[i]=1, then return to IDLE.
REQ-029 Minimum latency SHALL be 1 cycle: enable at cycle t gives ready at t+1.
REQ-030 fproc_data[i] SHALL hold its last response value until the next response.
REQ-031 fproc_enable[i] SHALL be ignored in WAIT and RESP, so back-to-back requests are accepted no sooner than the IDLE cycle following RESP.
REQ-032 Reading a slot SHALL NOT clear its valid bit; any number of cores may read the same slot, including in the same cycle.
REQ-033 Cores SHALL be fully independent, with no arbitration and no inter-core stall.

Reset
REQ-034 When reset is low, asynchronously: all FSMs SHALL go to IDLE, fproc_ready=0, fproc_data=0, all valid bits=0 and timer=0.
REQ-035 Slot data SHALL be cleared to 0 on reset.
REQ-036 Reset during WAIT or RESP SHALL drop the pending request with no ready pulse after release.
REQ-037 Operation SHALL resume on the first rising edge after reset goes high.

Verification
REQ-038 Write slot 3=0xDEADBEEF, then core 0 enable with id=3 two cycles later -> fproc_ready[0]=1 exactly one cycle after enable, data=0xDEADBEEF, ready low the next cycle.
REQ-039 Core 1 enable with id=5 while slot 5 is invalid, write slot 5=0x1234 four cycles later -> ready[1] one cycle after the write edge, data=0x1234, no earlier ready.
REQ-040 Core 2 enable with id=7 in the same cycle as meas_write_en to slot 7 with 0x55 and meas_clear=1 -> ready[2] next cycle with data=0x55; slot 2 (previously valid) reads as invalid afterwards.
REQ-041 Cores 0-3 all enable with id=N_MEAS (16) in one cycle when timer=100 -> all four ready next cycle, each with data=100.
REQ-042 Core 0 in WAIT on slot 9, reset asserted for 2 cycles, then slot 9 written -> no fproc_ready[0]; fproc_data[0]=0.
REQ-043 Timer preloaded near wrap (run 2^W-1 cycles, or W=8 build) and id >= N_MEAS requested at wrap -> data=all-ones, then 0 on the next request one cycle later.
